// File: rtl/q2b_pkg.sv
// Shared definitions for the Q2b motor driver: FSM encoding, counter width
// and the fixed WAITG / CHECK window lengths.
package q2b_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] WAITG_TIMEOUT = 4'd8;
  localparam logic [CNT_W-1:0] CHECK_LEN     = 4'd4;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    ONE,
    ZERO,
    LAST,
    WAITG,
    YDLY,
    YPULSE,
    CHECK
  } state_t;

  // Counter preload for the ONE phase; a length of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] ones_load(input logic [1:0] n);
    return (n == 2'd0) ? '0 : ({2'b00, n} - 4'd1);
  endfunction

endpackage

// File: rtl/q2b_downcounter.sv
// Loadable 4-bit down-counter that saturates at zero and flags when it is there.
module q2b_downcounter
  import q2b_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/q2b_motor_driver.sv
// Q2b motor driver: on a start pulse plays the x pattern, waits for the grant,
// answers with a y pulse and reports whether g settled to the expected level.
module q2b_motor_driver
  import q2b_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       f,
  input  logic       g,
  input  logic [3:0] pre_idle,
  input  logic [1:0] ones_len,
  input  logic [1:0] y_delay,
  input  logic       y_en,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  state_t           state;
  logic [1:0]       ones_l;
  logic [1:0]       y_delay_l;
  logic             y_en_l;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept;
  logic             expect_g;

  // The done cycle is already IDLE, so a start on that cycle must be refused.
  assign accept   = (state == IDLE) && f && !done;
  assign expect_g = y_en_l && (y_delay_l == 2'd0);

  always_ff @(posedge clk) begin
    if (accept) begin
      ones_l    <= ones_len;
      y_delay_l <= y_delay;
      y_en_l    <= y_en;
    end
  end

  q2b_downcounter u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // One shared counter: each phase preloads (length-1) on entry and leaves on zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = (pre_idle != 4'd0) ? (pre_idle - 4'd1) : ones_load(ones_len);
        end
      end
      PRE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = ones_load(ones_l);
        end else begin
          cnt_en = 1'b1;
        end
      end
      LAST: begin
        cnt_load = 1'b1;
        cnt_val  = WAITG_TIMEOUT - 4'd1;
      end
      WAITG: begin
        if (g && (y_delay_l != 2'd0)) begin
          cnt_load = 1'b1;
          cnt_val  = {2'b00, y_delay_l} - 4'd1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      YPULSE: begin
        cnt_load = 1'b1;
        cnt_val  = CHECK_LEN - 4'd1;
      end
      ONE, YDLY, CHECK: cnt_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      x     <= 1'b0;
      y     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (pre_idle != 4'd0) begin
              state <= PRE;
              x     <= 1'b0;
            end else begin
              state <= ONE;
              x     <= 1'b1;
            end
          end
        end
        PRE: begin
          if (cnt_zero) begin
            state <= ONE;
            x     <= 1'b1;
          end
        end
        ONE: begin
          if (cnt_zero) begin
            state <= ZERO;
            x     <= 1'b0;
          end
        end
        ZERO: begin
          state <= LAST;
          x     <= 1'b1;
        end
        LAST: begin
          state <= WAITG;
          x     <= 1'b0;
        end
        WAITG: begin
          if (g) begin
            if (y_delay_l == 2'd0) begin
              state <= YPULSE;
              y     <= y_en_l;
            end else begin
              state <= YDLY;
            end
          end else if (cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end
        end
        YDLY: begin
          if (cnt_zero) begin
            state <= YPULSE;
            y     <= y_en_l;
          end
        end
        YPULSE: begin
          state <= CHECK;
          y     <= 1'b0;
        end
        CHECK: begin
          if (cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (g == expect_g);
          end
        end
        default: begin
          state <= IDLE;
          x     <= 1'b0;
          y     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q2b_motor_driver.sv
// Bench for q2b_motor_driver: a controller stub drives f/g per scenario while a
// scoreboard compares the per-cycle {x,y,busy,done,pass} trace.
`timescale 1ns/1ps
module tb_q2b_motor_driver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       f;
  logic       g;
  logic [3:0] pre_idle;
  logic [1:0] ones_len;
  logic [1:0] y_delay;
  logic       y_en;
  logic       x, y, busy, done, pass;

  int         vectors     = 0;
  int         miscompares = 0;
  logic       cur_pass;
  logic [4:0] exp_q[$];
  logic [4:0] sb_exp;
  string      cur_test;
  int         cyc;

  always #5 clk = ~clk;

  q2b_motor_driver dut (
    .clk      (clk),
    .resetn   (resetn),
    .f        (f),
    .g        (g),
    .pre_idle (pre_idle),
    .ones_len (ones_len),
    .y_delay  (y_delay),
    .y_en     (y_en),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass)
  );

  // Scoreboard: pops one expected output word per cycle while a run is queued.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      vectors++;
      if ({x, y, busy, done, pass} !== sb_exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d {x,y,busy,done,pass}: got %b expected %b",
                 cur_test, cyc, {x, y, busy, done, pass}, sb_exp);
      end
    end
  end

  // Controller stub grant: high from WAITG offset gstart for glen cycles (0 = forever).
  function automatic logic g_at(input int c, input int l, input int gstart, input int glen);
    int first;
    if (gstart < 0) return 1'b0;
    first = l + 1 + gstart;
    return (c >= first) && ((glen == 0) || (c < first + glen));
  endfunction

  // Called mid-cycle; cycle 0 carries the f pulse. Queues the expected trace, then drives.
  task automatic drive_run(input int p, input int o, input int d, input logic e,
                           input int gstart, input int glen, input int fx1, input int fx2,
                           input bit scramble, output int dn);
    int   k, l, w0, yc, dc, n;
    bit   found;
    logic np, ex, ey, eb, ed, ep;
    k = (o == 0) ? 1 : o;
    l = p + k + 2;
    found = 1'b0;
    w0 = 0;
    for (int w = 0; w < 8; w++) begin
      if (!found && g_at(l + 1 + w, l, gstart, glen)) begin
        found = 1'b1;
        w0 = w;
      end
    end
    if (found) begin
      yc = l + 2 + w0 + d;
      dc = yc + 5;
      np = (g_at(yc + 4, l, gstart, glen) == (e && (d == 0)));
    end else begin
      yc = -1;
      dc = l + 9;
      np = 1'b0;
    end
    n = dc + 2;
    for (int c = 0; c <= n; c++) begin
      ex = ((c > p) && (c <= p + k)) || (c == l);
      ey = found && (c == yc) && e;
      eb = (c >= 1) && (c < dc);
      ed = (c == dc);
      ep = (c >= dc) ? np : cur_pass;
      exp_q.push_back({ex, ey, eb, ed, ep});
    end
    dn = 0;
    for (int c = 0; c <= n; c++) begin
      cyc = c;
      f = (c == 0) || (c == fx1) || (c == fx2);
      g = g_at(c, l, gstart, glen);
      if (c == 0) begin
        pre_idle = 4'(p);
        ones_len = 2'(o);
        y_delay  = 2'(d);
        y_en     = e;
      end else if (scramble) begin
        pre_idle = 4'($urandom_range(15, 0));
        ones_len = 2'($urandom_range(3, 0));
        y_delay  = 2'($urandom_range(3, 0));
        y_en     = 1'($urandom_range(1, 0));
      end
      #1;
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    f = 1'b0;
    g = 1'b0;
    cur_pass = np;
  endtask

  task automatic test_reset();
    int dn;
    cur_test = "reset";
    resetn = 1'b0; f = 1'b0; g = 1'b0;
    pre_idle = 4'd0; ones_len = 2'd0; y_delay = 2'd0; y_en = 1'b0;
    #1;
    vectors++;
    if ({x, y, busy, done, pass} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_state got %b expected 00000", {x, y, busy, done, pass});
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({x, y, busy, done, pass} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_held got %b expected 00000", {x, y, busy, done, pass});
    end
    resetn = 1'b1;
    cur_pass = 1'b0;
    cur_test = "s1_basic";
    drive_run(0, 1, 0, 1'b1, 0, 0, -1, -1, 1'b0, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL s1_done_pass got dones=%0d pass=%b expected dones=1 pass=1", dn, pass);
    end
  endtask

  task automatic test_pattern_delay();
    int dn;
    cur_test = "s2_delay";
    drive_run(3, 2, 2, 1'b1, 0, 2, -1, -1, 1'b0, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL s2_done_pass got dones=%0d pass=%b expected dones=1 pass=1", dn, pass);
    end
  endtask

  task automatic test_no_y();
    int dn;
    cur_test = "s3_no_y";
    drive_run(1, 0, 0, 1'b0, 1, 1, -1, -1, 1'b0, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL s3_done_pass got dones=%0d pass=%b expected dones=1 pass=1", dn, pass);
    end
  endtask

  task automatic test_timeout();
    int dn;
    cur_test = "s4_timeout";
    drive_run(2, 3, 1, 1'b1, -1, 0, -1, -1, 1'b0, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL s4_done_pass got dones=%0d pass=%b expected dones=1 pass=0", dn, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    int dcnt;
    cur_test = "s5_reset";
    pre_idle = 4'd0; ones_len = 2'd3; y_delay = 2'd0; y_en = 1'b1;
    f = 1'b1; g = 1'b0;
    @(negedge clk);
    f = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({x, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL s5_in_one got x,busy=%b expected 11", {x, busy});
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if ({x, y, busy, done, pass} !== 5'b00000) begin
      miscompares++;
      $display("FAIL s5_async_clear got %b expected 00000", {x, y, busy, done, pass});
    end
    @(negedge clk);
    resetn = 1'b1;
    cur_pass = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    vectors++;
    if (dcnt !== 0) begin
      miscompares++;
      $display("FAIL s5_no_done got active_cycles=%0d expected 0", dcnt);
    end
    @(negedge clk);
    cur_test = "s5_rerun";
    drive_run(1, 2, 0, 1'b1, 0, 0, -1, -1, 1'b0, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL s5_rerun got dones=%0d pass=%b expected dones=1 pass=1", dn, pass);
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    cur_test = "s6_ignore_f";
    // Extra f in the first WAITG cycle (5) and on the done cycle (14); config scrambled mid-run.
    drive_run(0, 2, 1, 1'b1, 2, 0, 5, 14, 1'b1, dn);
    vectors++;
    if (dn !== 1 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL s6_single_done got dones=%0d pass=%b expected dones=1 pass=0", dn, pass);
    end
  endtask

  task automatic test_random();
    int dn;
    for (int i = 0; i < 6; i++) begin
      cur_test = "random";
      drive_run(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                int'($urandom_range(9, 0)) - 1, int'($urandom_range(5, 0)),
                -1, -1, 1'b1, dn);
      vectors++;
      if (dn !== 1) begin
        miscompares++;
        $display("FAIL random_%0d_done got dones=%0d expected 1", i, dn);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern_delay();
    test_no_y();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
